// File: rtl/traffic_request_conditioner.sv
// traffic_request_conditioner
// Conditions the two raw vehicle-sensor switches (bit 0 = NS, bit 1 = EW)
// for the traffic-light controller: two-flop synchronizer, counter-based
// debounce, one-cycle request pulse on each debounced rise, and a sticky
// pending flag cleared by the controller's ack strobe.
//
// Build option: define REQ_LATCH_EN to build the sticky req_pending latch.
// Without it req_pending is a plain copy of the debounced switch level,
// ack is ignored and no latch flops exist.

// One direction: synchronizer, debounce counter, edge pulse, pending latch.
module traffic_request_conditioner_lane #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic switch_raw_i,
   input  logic ack_i,
   output logic switch_o,
   output logic req_pulse_o,
   output logic req_pending_o
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             switch_q, switch_d;
   logic             pulse_q, pulse_d;
   logic             rise;

   // Two-flop synchronizer; switch_raw is asynchronous to clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= switch_raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: count consecutive cycles of disagreement; any agreement
   // (including a glitch ending) drops the count back to zero. The counter
   // reaches CNT_MAX only on the cycle before the stable level flips, so it
   // never wraps.
   always_comb begin
      cnt_d    = '0;
      switch_d = switch_q;
      if (sync2_q != switch_q) begin
         if (cnt_q == CNT_MAX) begin
            switch_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Only a 0->1 change of the stable level is a request.
   always_comb begin
      rise    = switch_d & ~switch_q;
      pulse_d = rise;
   end

   // Stable level, counter and request pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         switch_q <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         switch_q <= switch_d;
         pulse_q  <= pulse_d;
      end
   end

   assign switch_o    = switch_q;
   assign req_pulse_o = pulse_q;

`ifdef REQ_LATCH_EN
   logic pend_q, pend_d;

   // A new rise beats a coincident ack so a fresh request is never lost;
   // ack with nothing pending leaves the flag at 0.
   always_comb begin
      pend_d = rise | (pend_q & ~ack_i);
   end

   // Sticky pending flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign req_pending_o = pend_q;
`else
   // No latch: pending simply mirrors the debounced level.
   logic unused_ack;
   assign unused_ack    = ack_i;
   assign req_pending_o = switch_q;
`endif

endmodule

// Top: one independent lane per direction.
module traffic_request_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] switch_raw,
   input  logic [1:0] ack,
   output logic [1:0] switch,
   output logic [1:0] req_pulse,
   output logic [1:0] req_pending
);

   localparam int NUM_DIR = 2;

   for (genvar i = 0; i < NUM_DIR; i++) begin : g_dir
      traffic_request_conditioner_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_lane (
         .clk           (clk),
         .reset         (reset),
         .switch_raw_i  (switch_raw[i]),
         .ack_i         (ack[i]),
         .switch_o      (switch[i]),
         .req_pulse_o   (req_pulse[i]),
         .req_pending_o (req_pending[i])
      );
   end

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench for traffic_request_conditioner with DEBOUNCE_CYCLES=4.
// req_pending expectations follow REQ_LATCH_EN: latched values when the
// macro is defined, the debounced switch level otherwise.
module tb_traffic_request_conditioner;

   localparam int D = 4;
`ifdef REQ_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] switch_raw, ack;
   logic [1:0] switch, req_pulse, req_pending;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0] raw;
      logic [1:0] ack;
      logic [1:0] sw;
      logic [1:0] pulse;
      logic [1:0] pend;   // value with the latch built
   } vec_t;

   vec_t vt[$];

   traffic_request_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk         (clk),
      .reset       (reset),
      .switch_raw  (switch_raw),
      .ack         (ack),
      .switch      (switch),
      .req_pulse   (req_pulse),
      .req_pending (req_pending)
   );

   always #5 clk = ~clk;

   task automatic add(input logic [1:0] r, a, s, p, pl, input int n = 1);
      vec_t v;
      v.raw = r; v.ack = a; v.sw = s; v.pulse = p; v.pend = pl;
      for (int k = 0; k < n; k++) vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [1:0] esw, ep, epl);
      logic [1:0] epend;
      epend = LATCH ? epl : esw;
      checks += 3;
      if (switch !== esw) begin
         errors++;
         $display("FAIL %s switch got %b want %b", name, switch, esw);
      end
      if (req_pulse !== ep) begin
         errors++;
         $display("FAIL %s req_pulse got %b want %b", name, req_pulse, ep);
      end
      if (req_pending !== epend) begin
         errors++;
         $display("FAIL %s req_pending got %b want %b", name, req_pending, epend);
      end
   endtask

   // Drive inputs (just after an edge), then advance one rising edge.
   task automatic step(input logic [1:0] r, a);
      switch_raw = r;
      ack        = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // raw=11 held across reset; rise on edge 6, ack both on edge 8
      add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(2'b11, 2'b00, 2'b11, 2'b11, 2'b11);
      add(2'b11, 2'b00, 2'b11, 2'b00, 2'b11);
      add(2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
      // release both: fall 6 edges after release, no pulse
      add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 5);
      add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // 3-cycle glitch on NS is rejected; ack with nothing pending ignored
      add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3);
      add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4);
      // NS held 10 then released 10: one pulse, pending held until ack
      add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(2'b01, 2'b00, 2'b01, 2'b01, 2'b01);
      add(2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 4);
      add(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 5);
      add(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 5);
      add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // EW rise with ack on the same edge: set wins; ack next cycle clears
      add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(2'b10, 2'b10, 2'b10, 2'b10, 2'b10);
      add(2'b10, 2'b10, 2'b10, 2'b00, 2'b00);
      add(2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
      // NS rises while EW stays high; then both fall together
      add(2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 5);
      add(2'b11, 2'b00, 2'b11, 2'b01, 2'b01);
      add(2'b11, 2'b00, 2'b11, 2'b00, 2'b01);
      add(2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 5);
      add(2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(2'b00, 2'b11, 2'b00, 2'b00, 2'b00);

      // Reset: outputs clear without a clock edge, and stay clear on edges
      reset = 1'b0; switch_raw = 2'b11; ack = 2'b00;
      #1 reset = 1'b1;
      #1 chk("reset_async", 2'b00, 2'b00, 2'b00);
      @(posedge clk); #1;
      chk("reset_hold", 2'b00, 2'b00, 2'b00);
      @(posedge clk); #1;
      reset = 1'b0;

      foreach (vt[i]) begin
         step(vt[i].raw, vt[i].ack);
         chk($sformatf("vec%0d", i + 1), vt[i].sw, vt[i].pulse, vt[i].pend);
      end

      // Exactly D synchronized cycles is long enough: rise, then fall
      for (int e = 1; e <= 10; e++) begin
         step((e <= 4) ? 2'b01 : 2'b00, 2'b00);
         if (e == 5)  chk("min_pulse_e5",  2'b00, 2'b00, 2'b00);
         if (e == 6)  chk("min_pulse_e6",  2'b01, 2'b01, 2'b01);
         if (e == 9)  chk("min_pulse_e9",  2'b01, 2'b00, 2'b01);
         if (e == 10) chk("min_pulse_e10", 2'b00, 2'b00, 2'b01);
      end

      // Rise again, then assert reset mid-cycle: everything clears at once
      for (int e = 1; e <= 6; e++) step(2'b01, 2'b00);
      chk("rerise", 2'b01, 2'b01, 2'b01);
      #2 reset = 1'b1;
      #1 chk("reset_midcycle", 2'b00, 2'b00, 2'b00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Reset pulsed on cycle 3 of a debounce discards the partial count
      for (int e = 1; e <= 3; e++) step(2'b01, 2'b00);
      chk("partial_count", 2'b00, 2'b00, 2'b00);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         step(2'b01, 2'b00);
         if (e == 5) chk("restart_e5", 2'b00, 2'b00, 2'b00);
         if (e == 6) chk("restart_e6", 2'b01, 2'b01, 2'b01);
      end
      step(2'b01, 2'b00);
      chk("restart_e7", 2'b01, 2'b00, 2'b01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/traffic_request_conditioner.md
TRAFFIC_REQUEST_CONDITIONER -- requirements
Module: traffic_request_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, number of consecutive clk cycles a synchronized input must differ from its stable value before the stable value changes; legal range 2..2^24.
REQ-002 Port: clk  input  1  system clock, single clock domain for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: switch_raw  input  2  raw vehicle-sensor switches, asynchronous to clk; bit 0 = NS, bit 1 = EW.
REQ-005 Port: ack  input  2  one-cycle request-serviced strobes from the traffic-light controller; bit 0 = NS, bit 1 = EW.
REQ-006 Port: switch  output  2  debounced stable level of switch_raw, for the traffic-light controller's switch input.
REQ-007 Port: req_pulse  output  2  one-cycle strobe on each debounced rising edge.
REQ-008 Port: req_pending  output  2  sticky request flag per direction.

Function
REQ-009 Each switch_raw bit SHALL pass through a dedicated two-flop synchronizer (sync1, sync2) before any other use.
REQ-010 Each bit SHALL own an independent counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-011 When sync2 equals switch, the counter SHALL load 0 on the next edge.
REQ-012 When sync2 differs from switch and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 When sync2 differs from switch and counter == DEBOUNCE_CYCLES-1, switch SHALL take sync2 and the counter SHALL load 0 on the same edge.
REQ-014 A clean level change on switch_raw that holds steady SHALL appear on switch exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-015 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave switch unchanged and reset the counter.
REQ-016 The counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1 only for the single cycle before the update.
REQ-017 req_pulse[i] SHALL be high for exactly the one cycle after the edge on which switch[i] goes 0->1; a 1->0 transition SHALL NOT generate a pulse.
REQ-018 req_pending[i] SHALL set on the edge on which switch[i] goes 0->1.
REQ-019 req_pending[i] SHALL clear on an edge on which ack[i] is high.
REQ-020 When set and ack[i] coincide on one edge, set SHALL win and req_pending[i] SHALL stay 1.
REQ-021 ack[i] while req_pending[i] is 0 SHALL have no effect.
REQ-022 The NS and EW bits SHALL be fully independent; simultaneous events on both bits SHALL each be handled as if alone.

Reset
REQ-023 While reset is high, the following SHALL be 0 immediately, without waiting for a clk edge: sync1, sync2, switch, req_pulse, req_pending and both counters.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count.
REQ-025 After reset deasserts, a switch_raw bit already held at 1 SHALL produce a debounced rise, one req_pulse and a req_pending set, after DEBOUNCE_CYCLES+2 edges.

Configuration
REQ-026 Macro REQ_LATCH_EN SHALL control the sticky latch.
REQ-027 With REQ_LATCH_EN defined, req_pending SHALL behave per REQ-018..REQ-021.
REQ-028 Without REQ_LATCH_EN, req_pending SHALL equal switch combinationally, ack SHALL be ignored, and no latch flops SHALL be synthesized.
REQ-029 All other behaviour SHALL be identical with and without REQ_LATCH_EN.

Verification (DEBOUNCE_CYCLES=4, REQ_LATCH_EN defined unless stated)
REQ-030 Reset high, switch_raw=2'b11 -> switch, req_pulse, req_pending = 0; after reset drops -> switch=2'b11 on edge 6, req_pulse=2'b11 for one cycle, req_pending=2'b11.
REQ-031 switch_raw[0] pulsed high for 3 cycles, then low -> switch[0] stays 0, req_pulse[0] stays 0.
REQ-032 switch_raw[1] 0->1 held, then ack[1] on the exact edge of the debounced rise -> req_pending[1]=1; ack[1] one cycle later -> req_pending[1]=0.
REQ-033 switch_raw=2'b01 held 10 cycles, then 2'b00 held 10 cycles -> exactly one req_pulse[0]; switch[0] falls 6 edges after the release; req_pending[0] stays 1 until ack.
REQ-034 Reset pulsed on cycle 3 of a 0->1 debounce -> the count restarts, and switch rises 6 edges after reset deasserts.
REQ-035 REQ_LATCH_EN undefined, run the REQ-033 stimulus -> req_pending[0] tracks switch[0] exactly; ack is ignored.
